wb_slave_mux_n: RTL and testbench

Parametrised Wishbone classic interconnect: one CPU master port fanned out to NUM_SLAVES slave ports (RAM, timer, UART, future peripherals). Decodes addresses from a parameter-defined base/mask map and tracks one outstanding transaction with an FSM. Returns registered ack/data to the master, and a bus error for unmapped addresses or hung slaves. Sits between the CPU and all memory-mapped slaves in the SoC top.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_addr_decoder.sv | 32 +++
 rtl/wb_slave_mux_n.sv | 156 +++++++++++++++
 tb/tb_wb_slave_mux_n.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared widths, FSM encoding and helpers for the Wishbone slave mux.
package wb_pkg;

  localparam int WB_DW_DEF = 32;
  localparam int WB_AW_DEF = 32;
  localparam int WB_SW_DEF = WB_DW_DEF / 8;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2,
    ST_DONE = 2'd3
  } wb_state_e;

  // A single-slave build still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_addr_decoder.sv
// Combinational base/mask address decoder; the lowest matching slave wins.
module wb_addr_decoder
  import wb_pkg::*;
#(
  parameter int              AW   = WB_AW_DEF,
  parameter int              N    = 3,
  parameter int              IDXW = idx_width(N),
  parameter logic [N*AW-1:0] BASE = '0,
  parameter logic [N*AW-1:0] MASK = '0
) (
  input  logic [AW-1:0]   addr_i,
  output logic [N-1:0]    hit_o,
  output logic [IDXW-1:0] idx_o,
  output logic            miss_o
);

  // Walk from the top down so a lower index overrides a higher one.
  always_comb begin
    hit_o = '0;
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if ((addr_i & MASK[k*AW +: AW]) == BASE[k*AW +: AW]) begin
        hit_o    = '0;
        hit_o[k] = 1'b1;
        idx_o    = IDXW'(k);
      end
    end
  end

  assign miss_o = ~|hit_o;

endmodule

// File: rtl/wb_slave_mux_n.sv
// Wishbone classic 1-to-N interconnect, one transaction in flight.
// Optional busy timeout is enabled by defining WB_MUX_TIMEOUT_EN.
module wb_slave_mux_n
  import wb_pkg::*;
#(
  parameter int WB_DATA_WIDTH  = WB_DW_DEF,
  parameter int WB_ADDR_WIDTH  = WB_AW_DEF,
  parameter int WB_SEL_WIDTH   = WB_SW_DEF,
  parameter int NUM_SLAVES     = 3,
  parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h9000_0000, 32'h8000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_MASK =
    {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_8000},
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [WB_DATA_WIDTH-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [WB_ADDR_WIDTH-1:0]              wb_m_addr_i,
  input  logic [WB_DATA_WIDTH-1:0]              wb_m_data_i,
  input  logic                                  wb_m_we_i,
  input  logic [WB_SEL_WIDTH-1:0]               wb_m_sel_i,
  input  logic                                  wb_m_stb_i,
  input  logic                                  wb_m_cyc_i,
  output logic                                  wb_m_ack_o,
  output logic                                  wb_m_err_o,
  output logic [WB_DATA_WIDTH-1:0]              wb_m_data_o,
  output logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0]   wb_s_addr_o,
  output logic [NUM_SLAVES*WB_DATA_WIDTH-1:0]   wb_s_data_o,
  output logic [NUM_SLAVES-1:0]                 wb_s_we_o,
  output logic [NUM_SLAVES*WB_SEL_WIDTH-1:0]    wb_s_sel_o,
  output logic [NUM_SLAVES-1:0]                 wb_s_stb_o,
  output logic [NUM_SLAVES-1:0]                 wb_s_cyc_o,
  input  logic [NUM_SLAVES-1:0]                 wb_s_ack_i,
  input  logic [NUM_SLAVES*WB_DATA_WIDTH-1:0]   wb_s_data_i,
  output logic                                  busy_o
);

  localparam int IDXW = idx_width(NUM_SLAVES);

  wb_state_e                state_q;
  logic [IDXW-1:0]          sel_q;
  logic [NUM_SLAVES-1:0]    sel_oh_q;
  logic                     ack_q;
  logic                     err_q;
  logic [WB_DATA_WIDTH-1:0] data_q;

  logic [NUM_SLAVES-1:0]    dec_hit;
  logic [IDXW-1:0]          dec_idx;
  logic                     dec_miss;
  logic                     req;
  logic                     slv_ack;
  logic [WB_DATA_WIDTH-1:0] slv_data;
  logic                     tmo_hit;

  wb_addr_decoder #(
    .AW   (WB_ADDR_WIDTH),
    .N    (NUM_SLAVES),
    .IDXW (IDXW),
    .BASE (SLAVE_BASE),
    .MASK (SLAVE_MASK)
  ) u_dec (
    .addr_i (wb_m_addr_i),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx),
    .miss_o (dec_miss)
  );

  assign req = wb_m_cyc_i & wb_m_stb_i;

  always_comb begin
    slv_ack  = 1'b0;
    slv_data = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (sel_q == IDXW'(k)) begin
        slv_ack  = wb_s_ack_i[k];
        slv_data = wb_s_data_i[k*WB_DATA_WIDTH +: WB_DATA_WIDTH];
      end
    end
  end

`ifdef WB_MUX_TIMEOUT_EN
  logic [15:0] tmo_q;
  assign tmo_hit = (tmo_q == 16'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Strobes follow the master live so an abandoned cycle drops them at once.
  assign wb_s_stb_o = (state_q == ST_BUSY && req) ? sel_oh_q : '0;
  assign wb_s_cyc_o = wb_s_stb_o;
  assign wb_s_addr_o = {NUM_SLAVES{wb_m_addr_i}};
  assign wb_s_data_o = {NUM_SLAVES{wb_m_data_i}};
  assign wb_s_we_o   = {NUM_SLAVES{wb_m_we_i}};
  assign wb_s_sel_o  = {NUM_SLAVES{wb_m_sel_i}};

  assign wb_m_ack_o  = ack_q;
  assign wb_m_err_o  = err_q;
  assign wb_m_data_o = data_q;
  assign busy_o      = (state_q != ST_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      sel_oh_q <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
`ifdef WB_MUX_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            sel_q    <= dec_idx;
            sel_oh_q <= dec_hit;
            state_q  <= dec_miss ? ST_ERR : ST_BUSY;
`ifdef WB_MUX_TIMEOUT_EN
            tmo_q    <= '0;
`endif
          end
        end
        ST_BUSY: begin
          if (!wb_m_cyc_i) begin
            state_q <= ST_IDLE;
          end else if (req && slv_ack) begin
            ack_q   <= 1'b1;
            data_q  <= slv_data;
            state_q <= ST_DONE;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            data_q  <= ERR_DATA;
            state_q <= ST_DONE;
          end
`ifdef WB_MUX_TIMEOUT_EN
          else begin
            tmo_q <= tmo_q + 16'd1;
          end
`endif
        end
        ST_ERR: begin
          err_q   <= 1'b1;
          data_q  <= ERR_DATA;
          state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_slave_mux_n.sv
// Self-checking bench for wb_slave_mux_n: directed plan steps plus random traffic.
module tb_wb_slave_mux_n;

  localparam int N = 3;
`ifdef WB_MUX_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic [31:0] base_a [N] = '{32'h0000_0000, 32'h8000_0000, 32'h9000_0000};
  logic [31:0] mask_a [N] = '{32'hFFFF_8000, 32'hFFFF_FFF0, 32'hFFFF_FFF0};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   m_addr, m_wdata, m_rdata;
  logic          m_we, m_stb, m_cyc, m_ack, m_err, busy;
  logic [3:0]    m_sel;
  logic [N*32-1:0] s_addr, s_wdata, s_rdata;
  logic [N-1:0]  s_we, s_stb, s_cyc, s_ack;
  logic [N*4-1:0] s_sel;
  logic [31:0]   sdata [N];

  int nvec = 0;
  int nmis = 0;

  assign s_rdata = {sdata[2], sdata[1], sdata[0]};

  wb_slave_mux_n #(
    .NUM_SLAVES     (N),
    .SLAVE_BASE     ({32'h9000_0000, 32'h8000_0000, 32'h0000_0000}),
    .SLAVE_MASK     ({32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_8000}),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .wb_m_addr_i (m_addr),
    .wb_m_data_i (m_wdata),
    .wb_m_we_i   (m_we),
    .wb_m_sel_i  (m_sel),
    .wb_m_stb_i  (m_stb),
    .wb_m_cyc_i  (m_cyc),
    .wb_m_ack_o  (m_ack),
    .wb_m_err_o  (m_err),
    .wb_m_data_o (m_rdata),
    .wb_s_addr_o (s_addr),
    .wb_s_data_o (s_wdata),
    .wb_s_we_o   (s_we),
    .wb_s_sel_o  (s_sel),
    .wb_s_stb_o  (s_stb),
    .wb_s_cyc_o  (s_cyc),
    .wb_s_ack_i  (s_ack),
    .wb_s_data_i (s_rdata),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode: first slave whose masked address equals its base.
  function automatic int ref_decode(input logic [31:0] a);
    for (int k = 0; k < N; k++)
      if ((a & mask_a[k]) == base_a[k]) return k;
    return -1;
  endfunction

  task automatic idle_master();
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_sel = '0;
  endtask

  // One master transaction; dly = cycles the slave waits after its first strobe.
  task automatic xact(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                      input logic [3:0] sel, input int dly);
    int idx, evt, sl;
    logic is_err, acks;
    logic [N-1:0] own, noise, exp_stb;
    logic [31:0] exp_d;
    idx    = ref_decode(addr);
    is_err = (idx < 0);
    evt    = is_err ? 2 : 2 + dly;
`ifdef WB_MUX_TIMEOUT_EN
    if (!is_err && dly >= TMO) begin
      is_err = 1'b1;
      evt    = TMO + 1;
    end
`endif
    acks  = (idx >= 0) && !is_err;
    own   = (idx >= 0) ? N'(1) << idx : '0;
    sl    = (idx >= 0) ? idx : 0;
    exp_d = is_err ? ERRD : sdata[sl];
    m_addr = addr; m_we = we; m_wdata = wd; m_sel = sel;
    m_cyc = 1'b1; m_stb = 1'b1;
    for (int t = 1; t <= evt + 1; t++) begin
      @(negedge clk);
      exp_stb = (t < evt) ? own : '0;
      chk("s_stb", 64'(s_stb), 64'(exp_stb));
      chk("s_cyc", 64'(s_cyc), 64'(exp_stb));
      chk("busy", 64'(busy), 64'(t <= evt));
      chk("m_ack", 64'(m_ack), 64'(!is_err && t == evt));
      chk("m_err", 64'(m_err), 64'(is_err && t == evt));
      if (t == evt) chk("m_data", 64'(m_rdata), 64'(exp_d));
      if (t == 1 && idx >= 0) begin
        chk("s_addr", 64'(s_addr[sl*32 +: 32]), 64'(addr));
        chk("s_we", 64'(s_we[sl]), 64'(we));
        chk("s_wdata", 64'(s_wdata[sl*32 +: 32]), 64'(wd));
        chk("s_sel", 64'(s_sel[sl*4 +: 4]), 64'(sel));
      end
      noise = N'($urandom_range(0, (1 << N) - 1));
      s_ack = (noise & ~own) | ((acks && t == 1 + dly) ? own : '0);
      if (t == evt) idle_master();
    end
    s_ack = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    s_ack = '0;
    idle_master();
    for (int k = 0; k < N; k++) sdata[k] = $urandom;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ack", 64'(m_ack), 64'd0);
    chk("rst_err", 64'(m_err), 64'd0);
    chk("rst_data", 64'(m_rdata), 64'd0);
    chk("rst_stb", 64'(s_stb), 64'd0);
    chk("rst_cyc", 64'(s_cyc), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // Read from slave0, ack one cycle after the strobe.
    sdata[0] = 32'h1234_5678;
    xact(32'h0000_0104, 1'b0, 32'h0, 4'hF, 1);
    // Write to slave1.
    xact(32'h8000_0004, 1'b1, 32'h0000_00A5, 4'b0001, 0);
    // Unmapped access.
    xact(32'h4000_0000, 1'b0, 32'h0, 4'hF, 0);
    // Slow slave2: ack on the eighth busy cycle, then never ack in time.
    xact(32'h9000_0004, 1'b0, 32'h0, 4'hF, 7);
    xact(32'h9000_0008, 1'b0, 32'h0, 4'hF, 20);

    // Master abandons a slave1 cycle after two busy cycles; late ack ignored.
    m_addr = 32'h8000_0008; m_we = 1'b0; m_sel = 4'hF; m_cyc = 1'b1; m_stb = 1'b1;
    @(negedge clk);
    chk("abort_stb1", 64'(s_stb), 64'b010);
    @(negedge clk);
    chk("abort_stb2", 64'(s_stb), 64'b010);
    idle_master();
    #1;
    chk("abort_drop", 64'(s_stb), 64'd0);
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    s_ack = 3'b010;
    @(negedge clk);
    chk("abort_ack", 64'(m_ack), 64'd0);
    chk("abort_err", 64'(m_err), 64'd0);
    chk("abort_idle", 64'(busy), 64'd0);
    s_ack = '0;
    sdata[0] = $urandom;
    xact(32'h0000_0010, 1'b0, 32'h0, 4'hF, 0);

    // Reset asserted while busy.
    m_addr = 32'h0000_0020; m_we = 1'b0; m_sel = 4'hF; m_cyc = 1'b1; m_stb = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("prerst_stb", 64'(s_stb), 64'b001);
    rst_n = 1'b0;
    #1;
    chk("arst_ack", 64'(m_ack), 64'd0);
    chk("arst_err", 64'(m_err), 64'd0);
    chk("arst_data", 64'(m_rdata), 64'd0);
    chk("arst_stb", 64'(s_stb), 64'd0);
    chk("arst_cyc", 64'(s_cyc), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    idle_master();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xact(32'h0000_0030, 1'b0, 32'h0, 4'hF, 2);

    // Random traffic across all slaves and unmapped space.
    for (int i = 0; i < 40; i++) begin
      int mode;
      logic [31:0] a;
      mode = $urandom_range(0, 3);
      if (mode < N) a = base_a[mode] | ($urandom & ~mask_a[mode]);
      else          a = $urandom;
      for (int k = 0; k < N; k++) sdata[k] = $urandom;
      xact(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
